// File: rtl/aes_key_expander.sv
// AES-128 key expander: expands KEY into round keys RK0..RK10, one round key per clock.
// The round-key buffer stays readable through RK_IDX in every state.
module aes_key_expander (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         START,
  input  logic [127:0] KEY,
  input  logic [3:0]   RK_IDX,
  output logic [127:0] RK_OUT,
  output logic         BUSY,
  output logic         DONE
);

  localparam int unsigned NUM_RK = 11;
  localparam int unsigned KEY_W  = 128;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NUM_RK - 1);

  // FIPS-197 forward S-box, entry 0 in the most significant byte
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] rk_q [NUM_RK];
  logic             busy_q, done_q;
  logic             load_key, write_rk;

  logic [CNT_W-1:0] prev_idx;
  logic [KEY_W-1:0] prev_rk, next_rk;
  logic [31:0]      w0, w1, w2, w3, t, n0, n1, n2, n3;
  logic [7:0]       rcon;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // Round constant for the round key being produced
  always_comb begin
    rcon = 8'h00;
    case (cnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  always_comb begin
    prev_idx = (cnt_q == '0) ? '0 : CNT_W'(cnt_q - CNT_W'(1));
    prev_rk  = rk_q[prev_idx];
    {w0, w1, w2, w3} = prev_rk;
    t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_rk = {n0, n1, n2, n3};
  end

  // Next-state and datapath enables
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_key = 1'b0;
    write_rk = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d  = ST_EXPAND;
          cnt_d    = CNT_W'(1);
          load_key = 1'b1;
        end
      end
      ST_EXPAND: begin
        write_rk = 1'b1;
        cnt_d    = CNT_W'(cnt_q + CNT_W'(1));
        if (cnt_q == LAST_RND) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        if (!START) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_RK; i++) rk_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == ST_EXPAND);
      done_q  <= (state_d == ST_DONE);
      if (load_key) rk_q[0] <= KEY;
      if (write_rk) rk_q[cnt_q] <= next_rk;
    end
  end

  assign RK_OUT = (RK_IDX <= LAST_RND) ? rk_q[RK_IDX] : '0;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed bench for aes_key_expander against FIPS-197 A.1 and zero-key round keys.
module tb_aes_key_expander;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         START;
  logic [127:0] KEY;
  logic [3:0]   RK_IDX;
  logic [127:0] RK_OUT;
  logic         BUSY;
  logic         DONE;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Z_RK1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK2    = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
  localparam logic [127:0] Z_RK10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [127:0] fips_rk [0:10];

  always #20 CLK = ~CLK;

  aes_key_expander dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .START  (START),
    .KEY    (KEY),
    .RK_IDX (RK_IDX),
    .RK_OUT (RK_OUT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b1; KEY = FIPS_KEY; RK_IDX = 4'd0;
    step(); step();
    n_checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: BUSY=%b DONE=%b, want 0 0", BUSY, DONE);
    end
    RESET = 1'b0; START = 1'b0;
    step();
    n_checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: BUSY=%b DONE=%b, want 0 0", BUSY, DONE);
    end
    for (int i = 0; i < 16; i++) begin
      RK_IDX = 4'(i); #1;
      n_checks++;
      if (RK_OUT !== 128'h0) begin
        n_fail++; $display("FAIL reset_rk[%0d]: got %h, want 0", i, RK_OUT);
      end
    end
  endtask

  task automatic test_fips_handshake();
    int busy_cycles = 0;
    int done_first  = 0;
    KEY = FIPS_KEY; START = 1'b1; RK_IDX = 4'd0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (BUSY) busy_cycles++;
      if (DONE && done_first == 0) done_first = i;
    end
    n_checks++;
    if (busy_cycles != 10) begin
      n_fail++; $display("FAIL fips_busy_cycles: got %0d, want 10", busy_cycles);
    end
    n_checks++;
    if (done_first != 11) begin
      n_fail++; $display("FAIL fips_done_latency: got %0d, want 11", done_first);
    end
    n_checks++;
    if (DONE !== 1'b1 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL fips_done_hold: BUSY=%b DONE=%b, want 0 1", BUSY, DONE);
    end
    for (int i = 0; i < 16; i++) begin
      RK_IDX = 4'(i); #1;
      n_checks++;
      if (i <= 10 && RK_OUT !== fips_rk[i]) begin
        n_fail++; $display("FAIL fips_rk[%0d]: got %h, want %h", i, RK_OUT, fips_rk[i]);
      end else if (i > 10 && RK_OUT !== 128'h0) begin
        n_fail++; $display("FAIL fips_oob[%0d]: got %h, want 0", i, RK_OUT);
      end
    end
    START = 1'b0;
    step();
    n_checks++;
    if (DONE !== 1'b0 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL fips_release: BUSY=%b DONE=%b, want 0 0", BUSY, DONE);
    end
    RK_IDX = 4'd10; #1;
    n_checks++;
    if (RK_OUT !== fips_rk[10]) begin
      n_fail++; $display("FAIL fips_retain: got %h, want %h", RK_OUT, fips_rk[10]);
    end
  endtask

  task automatic test_start_toggle_key_change();
    int done_first = 0;
    KEY = FIPS_KEY; START = 1'b1; RK_IDX = 4'd0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (DONE && done_first == 0) done_first = i;
      case (i)
        1: START = 1'b0;
        2: START = 1'b1;
        3: begin
          KEY = 128'h0123456789abcdeffedcba9876543210;
          START = 1'b0;
          RK_IDX = 4'd12; #1;
          n_checks++;
          if (BUSY !== 1'b1 || RK_OUT !== 128'h0) begin
            n_fail++; $display("FAIL expand_oob: BUSY=%b RK_OUT=%h, want 1 0", BUSY, RK_OUT);
          end
        end
        4: START = 1'b1;
        default: ;
      endcase
    end
    n_checks++;
    if (done_first != 11) begin
      n_fail++; $display("FAIL toggle_done_latency: got %0d, want 11", done_first);
    end
    RK_IDX = 4'd0; #1;
    n_checks++;
    if (RK_OUT !== FIPS_KEY) begin
      n_fail++; $display("FAIL keychg_rk0: got %h, want %h", RK_OUT, FIPS_KEY);
    end
    RK_IDX = 4'd10; #1;
    n_checks++;
    if (RK_OUT !== fips_rk[10]) begin
      n_fail++; $display("FAIL keychg_rk10: got %h, want %h", RK_OUT, fips_rk[10]);
    end
  endtask

  task automatic test_new_key();
    START = 1'b0;
    step();
    n_checks++;
    if (DONE !== 1'b0) begin
      n_fail++; $display("FAIL newkey_idle: DONE=%b, want 0", DONE);
    end
    KEY = 128'h0; START = 1'b1;
    for (int i = 0; i < 11; i++) step();
    n_checks++;
    if (DONE !== 1'b1) begin
      n_fail++; $display("FAIL newkey_done: DONE=%b, want 1", DONE);
    end
    RK_IDX = 4'd0; #1;
    n_checks++;
    if (RK_OUT !== 128'h0) begin
      n_fail++; $display("FAIL zero_rk0: got %h, want 0", RK_OUT);
    end
    RK_IDX = 4'd1; #1;
    n_checks++;
    if (RK_OUT !== Z_RK1) begin
      n_fail++; $display("FAIL zero_rk1: got %h, want %h", RK_OUT, Z_RK1);
    end
    RK_IDX = 4'd2; #1;
    n_checks++;
    if (RK_OUT !== Z_RK2) begin
      n_fail++; $display("FAIL zero_rk2: got %h, want %h", RK_OUT, Z_RK2);
    end
    RK_IDX = 4'd10; #1;
    n_checks++;
    if (RK_OUT !== Z_RK10) begin
      n_fail++; $display("FAIL zero_rk10: got %h, want %h", RK_OUT, Z_RK10);
    end
    START = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int done_first = 0;
    KEY = FIPS_KEY; START = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (BUSY !== 1'b1) begin
      n_fail++; $display("FAIL midrst_busy_before: BUSY=%b, want 1", BUSY);
    end
    RESET = 1'b1;
    step();
    n_checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin
      n_fail++; $display("FAIL midrst_flags: BUSY=%b DONE=%b, want 0 0", BUSY, DONE);
    end
    for (int i = 0; i < 16; i++) begin
      RK_IDX = 4'(i); #1;
      n_checks++;
      if (RK_OUT !== 128'h0) begin
        n_fail++; $display("FAIL midrst_rk[%0d]: got %h, want 0", i, RK_OUT);
      end
    end
    step();
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++; $display("FAIL midrst_override: BUSY=%b, want 0", BUSY);
    end
    RESET = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (DONE && done_first == 0) done_first = i;
    end
    n_checks++;
    if (done_first != 11) begin
      n_fail++; $display("FAIL midrst_done_latency: got %0d, want 11", done_first);
    end
    for (int i = 0; i <= 10; i++) begin
      RK_IDX = 4'(i); #1;
      n_checks++;
      if (RK_OUT !== fips_rk[i]) begin
        n_fail++; $display("FAIL midrst_rk_after[%0d]: got %h, want %h", i, RK_OUT, fips_rk[i]);
      end
    end
    START = 1'b0;
    step();
  endtask

  initial begin
    fips_rk[0]  = FIPS_KEY;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    RESET = 1'b1; START = 1'b0; KEY = '0; RK_IDX = '0;

    test_reset();
    test_fips_handshake();
    test_start_toggle_key_change();
    test_new_key();
    test_reset_mid();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

Interface
REQ-001 SHALL have port CLK  input  1  system clock; all state updates on the rising edge.
REQ-002 SHALL have port RESET  input  1  reset; synchronous, active-high.
REQ-003 SHALL have port START  input  1  level-held expansion request, same semantics as the AES start register bit.
REQ-004 SHALL have port KEY  input  128  cipher key; KEY[127:96] = w0, KEY[31:0] = w3.
REQ-005 SHALL have port RK_IDX  input  4  round-key read index, 0..10.
REQ-006 SHALL have port RK_OUT  output  128  round key selected by RK_IDX; {w4i, w4i+1, w4i+2, w4i+3}, w4i in [127:96].
REQ-007 SHALL have port BUSY  output  1  high while expansion is in progress.
REQ-008 SHALL have port DONE  output  1  high when all 11 round keys are valid.

Function
REQ-009 SHALL implement FIPS-197 AES-128 key expansion: 44 words stored as 11 x 128-bit round keys RK0..RK10.
REQ-010 SHALL use FSM states IDLE, EXPAND, DONE.
REQ-011 IDLE: BUSY=0, DONE=0. On an edge with START=1 (edge E0): latch KEY into RK0, set round counter to 1, go to EXPAND.
REQ-012 EXPAND: BUSY=1, DONE=0. At edge Ek (k=1..10): write RKk computed from RK(k-1) and increment the counter. After E10, go to DONE.
REQ-013 Round step: t = SubWord(RotWord(w3 of RK(k-1))) XOR {Rcon[k],24'h0}; w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'. All XOR is 32-bit and bitwise.
REQ-014 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-015 SubWord SHALL apply the FIPS-197 forward S-box to each byte, implemented as an internal 256-entry combinational ROM. Four lookups per cycle are permitted.
REQ-016 DONE: BUSY=0, DONE=1. Hold while START=1. When START=0 is sampled, go to IDLE with DONE=0 on the next cycle. The round-key buffer is retained.
REQ-017 Latency: DONE is first high in the cycle after E10, i.e. 11 edges after the START sample.
REQ-018 START held high continuously SHALL NOT retrigger an expansion. A new expansion requires a return through IDLE.
REQ-019 Changes to KEY after E0 SHALL be ignored until the next expansion.
REQ-020 START changes while in EXPAND SHALL be ignored. Expansion always completes, and the state then follows REQ-016.
REQ-021 RK_OUT SHALL be combinational from RK_IDX and the buffer. RK_IDX 11..15 SHALL return 128'h0.
REQ-022 RK_OUT reads during EXPAND SHALL return the current buffer contents. Entries not yet written hold the previous expansion's value, or 0 after reset.
REQ-023 Implementation SHALL be fully synchronous, with no latches and no combinational loops.

Reset
REQ-024 RESET=1 at any edge SHALL force IDLE, clear the round counter, and clear all RK0..RK10 to 0. RESET overrides START.
REQ-025 After reset: BUSY=0, DONE=0, RK_OUT=128'h0 for every RK_IDX.
REQ-026 RESET asserted mid-EXPAND SHALL abort the expansion. DONE SHALL NOT assert until a fresh START after RESET deasserts.

Verification
REQ-027 FIPS-197 key: KEY=2b7e151628aed2a6abf7158809cf4f3c, START=1 -> DONE after 11 edges; RK1=a0fafe1788542cb123a339392a6c7605; RK10=d014f9a8c9ee2589e13f0cc8b6630ca6; RK0 equals KEY.
REQ-028 Zero key: KEY=0, START=1 -> RK1=62636363626363636263636362636363; RK10=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-029 Handshake: START held high 30 cycles -> BUSY high for exactly 10 cycles, then DONE stays high. START=0 -> DONE=0 next cycle. START held high -> no second BUSY pulse. START toggled in EXPAND -> no effect.
REQ-030 Key change: KEY changed at E3 -> final RK10 matches the key latched at E0. A second START with a new key, after returning through IDLE -> buffer fully replaced with the new expansion.
REQ-031 Reset mid-run: RESET at E5 -> BUSY=0, DONE=0, all RK_OUT=0. Then START -> full correct expansion.
REQ-032 Index bounds: RK_IDX=11..15 -> RK_OUT=0 in every state. RK_IDX sweep 0..10 after DONE -> all 11 round keys match the golden model.
